// File: rtl/pp_burst_packer.sv
// Drains a show-ahead push/pop FIFO into framed bursts (sop/eop/len) on a registered
// valid/ready stream; full bursts go out at BURST_LEN words, short ones after TIMEOUT cycles.
module pp_burst_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 5,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [CNT_W-1:0]      fifo_count,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [CNT_W-1:0]      m_len,
    output logic                  busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] B_LEN  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic {WAIT, SEND} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [CNT_W-1:0] beats_left, beats_left_nx;
    logic [CNT_W-1:0] len_q, len_q_nx;
    logic             pop;
    logic             first_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT;
            timer      <= '0;
            beats_left <= '0;
            len_q      <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            beats_left <= beats_left_nx;
            len_q      <= len_q_nx;
        end
    end

    // The timer only advances while enabled; an empty FIFO always clears it.
    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        beats_left_nx = beats_left;
        len_q_nx      = len_q;
        pop           = (state == SEND) && !fifo_empty && (beats_left != '0)
                        && (!m_valid || m_ready);
        first_beat    = (beats_left == len_q);
        case (state)
            WAIT: begin
                if (enable && (fifo_count >= B_LEN)) begin
                    state_nx      = SEND;
                    len_q_nx      = B_LEN;
                    beats_left_nx = B_LEN;
                    timer_nx      = '0;
                end else if (enable && (fifo_count != '0) && (timer == T_LAST)) begin
                    state_nx      = SEND;
                    len_q_nx      = fifo_count;
                    beats_left_nx = fifo_count;
                    timer_nx      = '0;
                end else if (fifo_count == '0) begin
                    timer_nx = '0;
                end else if (enable && (timer != T_LAST)) begin
                    timer_nx = timer + 1'b1;
                end
            end
            SEND: begin
                if (pop) begin
                    beats_left_nx = beats_left - ONE;
                    if (beats_left == ONE) begin
                        state_nx = WAIT;
                    end
                end
            end
            default: state_nx = WAIT;
        endcase
    end

    // A pop refills the output register even while the old beat is being accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            m_len   <= '0;
        end else if (pop) begin
            m_valid <= 1'b1;
            m_data  <= fifo_data;
            m_sop   <= first_beat;
            m_eop   <= (beats_left == ONE);
            m_len   <= first_beat ? len_q : '0;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            m_len   <= '0;
        end
    end

    assign fifo_pop = pop;
    assign busy     = (state == SEND) || m_valid;

endmodule

// File: tb/tb_pp_burst_packer.sv
// Scoreboard bench for pp_burst_packer: a behavioural show-ahead FIFO feeds the DUT and
// a negedge monitor compares every accepted beat against expectations queued by each test.
module tb_pp_burst_packer;

    localparam int DW = 32;
    localparam int CW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [CW-1:0] len;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] fifo_data;
    logic          fifo_pop;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;
    logic [CW-1:0] m_len;
    logic          busy;

    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          fifo_clear = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    beat_t exp_q[$];
    beat_t held;
    logic  stalled;

    pp_burst_packer #(.DATA_WIDTH(DW), .CNT_W(CW), .BURST_LEN(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .m_len      (m_len),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural show-ahead FIFO with registered occupancy.
    logic [DW-1:0] fmem [0:63];
    logic [5:0]    wptr, rptr;
    logic [6:0]    fcnt;

    always @(posedge clk) begin
        if (fifo_clear) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (push_en) begin
                fmem[wptr] <= push_data;
                wptr       <= wptr + 1'b1;
            end
            if (fifo_pop && fcnt != 7'd0) rptr <= rptr + 1'b1;
            fcnt <= fcnt + {6'd0, push_en} - {6'd0, (fifo_pop && fcnt != 7'd0)};
        end
    end

    assign fifo_empty = (fcnt == 7'd0);
    assign fifo_count = fcnt[CW-1:0];
    assign fifo_data  = fmem[rptr];

    // Monitor: handshake-accurate sampling at negedge (inputs change #1 after posedge).
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                tests_run++;
                if (m_valid !== 1'b1 || m_data !== held.data || m_sop !== held.sop
                    || m_eop !== held.eop || m_len !== held.len) begin
                    tests_failed++;
                    $display("[TB] FAIL hold_stable: got v=%b d=%h sop=%b eop=%b len=%0d, want v=1 d=%h sop=%b eop=%b len=%0d",
                             m_valid, m_data, m_sop, m_eop, m_len, held.data, held.sop, held.eop, held.len);
                end
            end
            if (m_valid && !m_ready) begin
                tests_run++;
                if (fifo_pop !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL pop_during_stall: fifo_pop=%b, want 0", fifo_pop);
                end
            end
            if (fifo_pop === 1'b1) begin
                tests_run++;
                if (fifo_empty) begin
                    tests_failed++;
                    $display("[TB] FAIL pop_when_empty: fifo_pop=1 with fifo_empty=1, want 0");
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected_beat: got d=%h sop=%b eop=%b len=%0d, want no beat",
                             m_data, m_sop, m_eop, m_len);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_sop !== e.sop || m_eop !== e.eop || m_len !== e.len) begin
                        tests_failed++;
                        $display("[TB] FAIL beat: got d=%h sop=%b eop=%b len=%0d, want d=%h sop=%b eop=%b len=%0d",
                                 m_data, m_sop, m_eop, m_len, e.data, e.sop, e.eop, e.len);
                    end
                end
            end
            stalled <= m_valid && !m_ready;
            held    <= '{data: m_data, sop: m_sop, eop: m_eop, len: m_len};
        end
    end

    function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic s, input logic e,
                                      input logic [CW-1:0] l);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        b.len  = l;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = base + DW'(i);
            tick();
        end
        push_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        fifo_clear = 1'b1;
        repeat (3) tick();
        tests_run += 7;
        if (m_valid !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_m_valid: got %b, want 0", m_valid); end
        if (m_data !== '0)     begin tests_failed++; $display("[TB] FAIL reset_m_data: got %h, want 0", m_data); end
        if (m_sop !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_m_sop: got %b, want 0", m_sop); end
        if (m_eop !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_m_eop: got %b, want 0", m_eop); end
        if (m_len !== '0)      begin tests_failed++; $display("[TB] FAIL reset_m_len: got %0d, want 0", m_len); end
        if (busy !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        if (fifo_pop !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fifo_pop: got %b, want 0", fifo_pop); end
        fifo_clear = 1'b0;
        reset_n    = 1'b1;
        tick();
    endtask

    task automatic test_full_burst();
        int n;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(32'hA000_0000 + DW'(i), i == 0, i == 3, (i == 0) ? 5'd4 : 5'd0));
        push_words(32'hA000_0000, 4);
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("[TB] FAIL full_latency: first beat after %0d cycles, want 2", n);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (m_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL full_stream: beat %0d m_valid=%b, want 1", k, m_valid);
            end
            tick();
        end
        tests_run += 2;
        if (m_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_end_valid: got %b, want 0", m_valid); end
        if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL full_count: got %0d, want 0", fifo_count); end
        repeat (3) tick();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL full_left: %0d beats missing, want 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        enable  = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(mk_beat(32'hB000_0000, 1'b1, 1'b0, 5'd2));
        exp_q.push_back(mk_beat(32'hB000_0001, 1'b0, 1'b1, 5'd0));
        push_words(32'hB000_0000, 2);
        repeat (6) tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_early: busy=%b 7 cycles after first word, want 0", busy); end
        tick();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_fire: busy=%b 8 cycles after first word, want 1", busy); end
        repeat (8) tick();
        tests_run += 2;
        if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL timeout_left: %0d beats missing, want 0", exp_q.size()); end
        if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL timeout_count: got %0d, want 0", fifo_count); end
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        pat    = 6'b101001;
        enable = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(32'hC000_0000 + DW'(i), i == 0, i == 3, (i == 0) ? 5'd4 : 5'd0));
        for (int i = 0; i < 40; i++) begin
            m_ready   = pat[i % 6];
            push_en   = (i < 4);
            push_data = 32'hC000_0000 + DW'(i);
            tick();
        end
        push_en = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        tests_run += 3;
        if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL bp_left: %0d beats missing, want 0", exp_q.size()); end
        if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d, want 0", fifo_count); end
        if (busy !== 1'b0)     begin tests_failed++; $display("[TB] FAIL bp_busy: got %b, want 0", busy); end
    endtask

    task automatic test_overfill();
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++)
            exp_q.push_back(mk_beat(32'hD000_0000 + DW'(i), (i % 4) == 0,
                                    (i == 3) || (i == 7) || (i == 8),
                                    (i == 0 || i == 4) ? 5'd4 : (i == 8) ? 5'd1 : 5'd0));
        push_words(32'hD000_0000, 9);
        tests_run++;
        if (fifo_count !== 5'd9) begin tests_failed++; $display("[TB] FAIL over_preload: count=%0d, want 9", fifo_count); end
        enable = 1'b1;
        repeat (40) tick();
        tests_run += 2;
        if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL over_left: %0d beats missing, want 0", exp_q.size()); end
        if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL over_count: got %0d, want 0", fifo_count); end
    endtask

    task automatic test_enable();
        int n;
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(32'hE000_0000 + DW'(i), i == 0, i == 3, (i == 0) ? 5'd4 : 5'd0));
        push_words(32'hE000_0000, 4);
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (fifo_pop !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL en_gate: fifo_pop=%b busy=%b, want 0 0", fifo_pop, busy);
            end
            tick();
        end
        tests_run++;
        if (fifo_count !== 5'd4) begin tests_failed++; $display("[TB] FAIL en_count: got %0d, want 4", fifo_count); end
        enable = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL en_start: busy=%b, want 1", busy); end
        n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        enable = 1'b0;
        repeat (10) tick();
        tests_run += 3;
        if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL en_left: %0d beats missing, want 0", exp_q.size()); end
        if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL en_count_end: got %0d, want 0", fifo_count); end
        if (busy !== 1'b0)     begin tests_failed++; $display("[TB] FAIL en_busy_end: got %b, want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(32'hF000_0000 + DW'(i), i == 0, i == 3, (i == 0) ? 5'd4 : 5'd0));
        push_words(32'hF000_0000, 4);
        n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        reset_n    = 1'b0;
        fifo_clear = 1'b1;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_sop !== 1'b0 || m_eop !== 1'b0 || fifo_pop !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid: v=%b sop=%b eop=%b pop=%b busy=%b, want all 0",
                     m_valid, m_sop, m_eop, fifo_pop, busy);
        end
        exp_q.delete();
        repeat (2) tick();
        fifo_clear = 1'b0;
        reset_n    = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || fifo_count !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rst_release: busy=%b count=%0d, want 0 0", busy, fifo_count);
        end
        exp_q.push_back(mk_beat(32'h1234_5678, 1'b1, 1'b1, 5'd1));
        push_words(32'h1234_5678, 1);
        repeat (7) tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_timer_early: busy=%b, want 0", busy); end
        tick();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_timer_fire: busy=%b, want 1", busy); end
        repeat (6) tick();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL rst_left: %0d beats missing, want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_backpressure();
        test_overfill();
        test_enable();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at 100000 ns, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
